decim_clk_ctrl: RTL and testbench
=================================

DECIM_CLK_CTRL -- requirements
Module: decim_clk_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 8: cycles mmcm_reset is held high per reset attempt, minimum 1.
REQ-002 Parameter LOCK_TIMEOUT, default 2097152: cycles allowed in WAIT_LOCK before an attempt fails.
REQ-003 Parameter FLUSH_CYCLES, default 64: cycles the datapath is held disabled after lock, at least the FIR ORDER.
REQ-004 Parameter MAX_RETRY, default 3: failed lock attempts before FAIL, minimum 1.
REQ-005 clk  in  1  single clock for all logic; the MMCM input clock domain.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle pulse that begins the bring-up sequence.
REQ-008 stop  in  1  one-cycle pulse that returns the block to IDLE.
REQ-009 mmcm_locked  in  1  MMCM LOCKED, asynchronous to clk.
REQ-010 bypass_req  in  1  requested decimator bypass mode (PS.BYPASS source).
REQ-011 mmcm_reset  out  1  MMCM RST.
REQ-012 dp_enable  out  1  gates datapath valid downstream of the decimator.
REQ-013 bypass  out  1  applied bypass mode.
REQ-014 state  out  3  current FSM state encoding.
REQ-015 err  out  1  high while in FAIL.
REQ-016 lock_lost_cnt  out  16  saturating count of lock losses seen in RUN.

Function
REQ-017 mmcm_locked SHALL pass through a 2-flop synchronizer (locked_s) before any use.
REQ-018 The FSM SHALL have states IDLE=0, RESET=1, WAIT_LOCK=2, FLUSH=3, RUN=4, FAIL=5.
REQ-019 In IDLE the outputs SHALL be: mmcm_reset=1, dp_enable=0; start -> RESET with the retry count cleared.
REQ-020 In RESET, mmcm_reset SHALL be 1 for exactly RST_CYCLES cycles, then the FSM goes to WAIT_LOCK with the timer cleared.
REQ-021 In WAIT_LOCK (mmcm_reset=0): locked_s=1 -> FLUSH; a timer reaching LOCK_TIMEOUT-1 -> retry+1, then FAIL if retry equals MAX_RETRY, otherwise RESET.
REQ-022 FLUSH SHALL keep dp_enable=0 for FLUSH_CYCLES cycles, then go to RUN and clear retry; locked_s=0 during FLUSH -> RESET.
REQ-023 RUN SHALL drive dp_enable=1; locked_s=0 -> lock_lost_cnt+1 (saturating at 0xFFFF) and RESET, with dp_enable deasserted in the same cycle as the transition.
REQ-024 FAIL SHALL drive err=1, mmcm_reset=1, dp_enable=0; start -> RESET with retry cleared.
REQ-025 stop in any state SHALL force IDLE next cycle; stop SHALL win over start and over a lock event in the same cycle.
REQ-026 start SHALL be ignored in RESET, WAIT_LOCK, FLUSH and RUN.
REQ-027 bypass SHALL load bypass_req only in IDLE, FAIL, and on the cycle of entry to FLUSH; it SHALL hold otherwise, so there is no mode change while dp_enable=1.
REQ-028 All outputs SHALL be registered; the latency from the mmcm_locked rise to state=FLUSH SHALL be 3 clk cycles.
REQ-029 Counter widths SHALL be the $clog2 of the respective parameter plus 1; counters SHALL NOT wrap inside a state.

Reset
REQ-030 With rst_n=0 the block SHALL be: state=IDLE, mmcm_reset=1, dp_enable=0, bypass=0, err=0, lock_lost_cnt=0, all counters 0, synchronizer flops 0.
REQ-031 Reset SHALL assert asynchronously and release synchronously through a 2-flop rst_n synchronizer inside the block.
REQ-032 An rst_n assertion mid-sequence SHALL drop dp_enable immediately, with no sequence resume afterwards.

Structure
REQ-033 The shared package decim_ctrl_pkg SHALL hold the decim_ctrl_state_t enum and a DECIM_CTRL_STATUS struct {state, err, lock_lost_cnt} for regs_file mapping.
REQ-034 The lock synchronizer SHALL use the existing level_sync; there SHALL be no other sub-module.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=16, FLUSH_CYCLES=5, MAX_RETRY=2)
REQ-035 Start, then raise the lock 3 cycles after mmcm_reset falls -> mmcm_reset high 4 cycles, FLUSH 3 cycles after the lock rise, dp_enable=1 5 cycles later.
REQ-036 Start with the lock held at 0 -> two 4-cycle reset pulses 16 cycles apart, then state=5 and err=1.
REQ-037 In RUN, drop the lock for 1 cycle of locked_s -> dp_enable=0 and lock_lost_cnt=1; the sequence restarts with RESET.
REQ-038 Start and stop in the same cycle in IDLE, then stop in WAIT_LOCK -> state stays or returns to IDLE, mmcm_reset=1.
REQ-039 Toggle bypass_req during RUN -> bypass unchanged; it is applied at the next FLUSH entry.
REQ-040 Assert rst_n=0 in FLUSH -> all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/decim_clk_ctrl_pkg.sv
// Shared types for the decimator clock bring-up controller and its register-file mapping.
package decim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } decim_ctrl_state_t;

  typedef struct packed {
    decim_ctrl_state_t state;
    logic              err;
    logic [15:0]       lock_lost_cnt;
  } DECIM_CTRL_STATUS;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/decim_clk_ctrl_if.sv
// Control/status bundle between the MMCM bring-up sequencer and its host logic.
interface decim_clk_ctrl_if;
  import decim_ctrl_pkg::*;

  logic              start;
  logic              stop;
  logic              mmcm_locked;
  logic              bypass_req;
  logic              mmcm_reset;
  logic              dp_enable;
  logic              bypass;
  decim_ctrl_state_t state;
  logic              err;
  logic [15:0]       lock_lost_cnt;

  modport master (
    output start, stop, mmcm_locked, bypass_req,
    input  mmcm_reset, dp_enable, bypass, state, err, lock_lost_cnt
  );

  modport slave (
    input  start, stop, mmcm_locked, bypass_req,
    output mmcm_reset, dp_enable, bypass, state, err, lock_lost_cnt
  );

endinterface

// File: rtl/decim_clk_ctrl_level_sync.sv
// Multi-flop level synchronizer for a slowly changing asynchronous input.
module level_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/decim_clk_ctrl.sv
// MMCM bring-up sequencer: resets the MMCM, waits for lock with retries, flushes
// the decimator and then enables the datapath, restarting on lock loss.
module decim_clk_ctrl
  import decim_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 2097152,
  parameter int FLUSH_CYCLES = 64,
  parameter int MAX_RETRY    = 3
) (
  input logic             clk,
  input logic             rst_n,
  decim_clk_ctrl_if.slave bus
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int LW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam int YW = $clog2(MAX_RETRY) + 1;

  // Async assert, sync release: everything below resets off rst_int_n.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic locked_s;

  level_sync #(.STAGES(2)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_int_n),
    .d_i   (bus.mmcm_locked),
    .q_o   (locked_s)
  );

  decim_ctrl_state_t state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic [YW-1:0]     retry_q, retry_d;
  logic [15:0]       lost_q, lost_d;
  logic              bypass_q, bypass_d;
  logic              mmcm_reset_q, mmcm_reset_d;
  logic              dp_en_q, dp_en_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    lock_cnt_d  = '0;
    flush_cnt_d = '0;
    retry_d     = retry_q;
    lost_d      = lost_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else                                  rst_cnt_d = rst_cnt_q + RW'(1);
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_FLUSH;
        end else if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + YW'(1);
          state_d = (retry_d == YW'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      ST_FLUSH: begin
        if (!locked_s) begin
          state_d = ST_RESET;
        end else if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET;
          lost_d  = sat_inc16(lost_q);
        end
      end
      ST_FAIL: begin
        if (bus.start) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // stop overrides start and any lock event decided above
    if (bus.stop) begin
      state_d     = ST_IDLE;
      rst_cnt_d   = '0;
      lock_cnt_d  = '0;
      flush_cnt_d = '0;
      retry_d     = retry_q;
      lost_d      = lost_q;
    end
  end

  // Outputs are registered from the next state so they change together with state.
  always_comb begin
    bypass_d = bypass_q;
    if ((state_q == ST_IDLE) || (state_q == ST_FAIL) ||
        ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)))
      bypass_d = bus.bypass_req;
    mmcm_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
    dp_en_d      = (state_d == ST_RUN);
    err_d        = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      retry_q      <= '0;
      lost_q       <= '0;
      bypass_q     <= 1'b0;
      mmcm_reset_q <= 1'b1;
      dp_en_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      bypass_q     <= bypass_d;
      mmcm_reset_q <= mmcm_reset_d;
      dp_en_q      <= dp_en_d;
      err_q        <= err_d;
    end
  end

  DECIM_CTRL_STATUS status;
  assign status = '{state: state_q, err: err_q, lock_lost_cnt: lost_q};

  assign bus.state         = status.state;
  assign bus.err           = status.err;
  assign bus.lock_lost_cnt = status.lock_lost_cnt;
  assign bus.mmcm_reset    = mmcm_reset_q;
  assign bus.dp_enable     = dp_en_q;
  assign bus.bypass        = bypass_q;

endmodule

// File: tb/tb_decim_clk_ctrl.sv
// Directed bench for decim_clk_ctrl with a cycle-level reference model of the bring-up rules.
module tb_decim_clk_ctrl;

  localparam int RST  = 4;
  localparam int TO   = 16;
  localparam int FL   = 5;
  localparam int MAXR = 2;

  logic clk;
  logic rst_n;

  decim_clk_ctrl_if bus ();

  decim_clk_ctrl #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TO),
    .FLUSH_CYCLES (FL),
    .MAX_RETRY    (MAXR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: st = state number, dwell = cycles already spent in st,
  // s1/s2 = the two lock synchronizer samples, hold = edges still swallowed by reset release.
  typedef struct {
    int st;
    int dwell;
    int retry;
    int lost;
    bit byp;
    bit s1;
    bit s2;
    int hold;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{default: 0};
    r.hold = 2;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, bit start, bit stop, bit lock, bit breq);
    mdl_t n;
    int   nxt;
    bit   lk;
    if (c.hold > 0) begin
      n = mdl_reset();
      n.hold = c.hold - 1;
      return n;
    end
    n    = c;
    nxt  = c.st;
    lk   = c.s2;
    n.s1 = lock;
    n.s2 = c.s1;
    case (c.st)
      0: if (start) begin nxt = 1; n.retry = 0; end
      1: if (c.dwell + 1 >= RST) nxt = 2;
      2: begin
        if (lk) nxt = 3;
        else if (c.dwell + 1 >= TO) begin
          n.retry = c.retry + 1;
          nxt = (n.retry >= MAXR) ? 5 : 1;
        end
      end
      3: begin
        if (!lk) nxt = 1;
        else if (c.dwell + 1 >= FL) begin nxt = 4; n.retry = 0; end
      end
      4: if (!lk) begin nxt = 1; n.lost = (c.lost < 65535) ? c.lost + 1 : 65535; end
      5: if (start) begin nxt = 1; n.retry = 0; end
      default: nxt = 0;
    endcase
    if (stop) begin
      nxt = 0;
      n.retry = c.retry;
      n.lost = c.lost;
    end
    if (c.st == 0 || c.st == 5 || (nxt == 3 && c.st != 3)) n.byp = breq;
    n.dwell = (nxt == c.st) ? c.dwell + 1 : 0;
    n.st = nxt;
    return n;
  endfunction

  mdl_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mdl_step(m, bus.start, bus.stop, bus.mmcm_locked, bus.bypass_req);
  end

  always @(negedge clk) begin
    check("state",      bus.state,         m.st);
    check("mmcm_reset", bus.mmcm_reset,    (m.st == 0 || m.st == 1 || m.st == 5));
    check("dp_enable",  bus.dp_enable,     (m.st == 4));
    check("err",        bus.err,           (m.st == 5));
    check("bypass",     bus.bypass,        m.byp);
    check("lost_cnt",   bus.lock_lost_cnt, m.lost);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.mmcm_locked = 1'b0;
    bus.bypass_req  = 1'b0;
    tick(2);
    check("rst_state", bus.state, 0);
    check("rst_mmcm_reset", bus.mmcm_reset, 1);
    check("rst_dp_enable", bus.dp_enable, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    tick(4);

    // Normal bring-up with lock arriving 3 cycles after mmcm_reset falls
    pulse_start();
    check("t1_reset_entry", bus.state, 1);
    tick(3);
    check("t1_reset_last", bus.state, 1);
    check("t1_reset_high", bus.mmcm_reset, 1);
    tick(1);
    check("t1_wait_entry", bus.state, 2);
    check("t1_reset_low", bus.mmcm_reset, 0);
    tick(3);
    bus.mmcm_locked = 1'b1;
    tick(2);
    check("t1_lock_lat2", bus.state, 2);
    tick(1);
    check("t1_flush_lat3", bus.state, 3);
    tick(4);
    check("t1_flush_dp", bus.dp_enable, 0);
    tick(1);
    check("t1_run", bus.state, 4);
    check("t1_run_dp", bus.dp_enable, 1);

    // Bypass request changes in RUN are held off
    bus.bypass_req = 1'b1;
    tick(3);
    check("t3_bypass_hold", bus.bypass, 0);

    // One-cycle lock loss in RUN
    bus.mmcm_locked = 1'b0;
    tick(1);
    bus.mmcm_locked = 1'b1;
    tick(1);
    check("t2_still_run", bus.dp_enable, 1);
    tick(1);
    check("t2_restart", bus.state, 1);
    check("t2_dp_drop", bus.dp_enable, 0);
    check("t2_lost_cnt", bus.lock_lost_cnt, 1);
    tick(4);
    check("t3_wait_bypass", bus.bypass, 0);
    tick(1);
    check("t3_flush", bus.state, 3);
    check("t3_bypass_applied", bus.bypass, 1);
    tick(5);
    check("t3_run_again", bus.state, 4);

    // No lock at all: retries exhaust into FAIL
    bus.mmcm_locked = 1'b0;
    bus.bypass_req  = 1'b0;
    pulse_stop();
    check("t4_stop_run", bus.state, 0);
    tick(3);
    pulse_start();
    tick(4);
    check("t4_wait1", bus.state, 2);
    tick(15);
    check("t4_wait1_end", bus.state, 2);
    tick(1);
    check("t4_reset2", bus.state, 1);
    check("t4_reset2_hi", bus.mmcm_reset, 1);
    tick(4);
    check("t4_wait2", bus.state, 2);
    tick(15);
    check("t4_wait2_end", bus.err, 0);
    tick(1);
    check("t4_fail", bus.state, 5);
    check("t4_err", bus.err, 1);
    check("t4_fail_reset", bus.mmcm_reset, 1);

    // Stop handling and start/stop priority
    pulse_stop();
    check("t5_fail_stop", bus.state, 0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t5_stop_wins", bus.state, 0);
    check("t5_idle_reset", bus.mmcm_reset, 1);
    pulse_start();
    tick(4);
    check("t5_wait", bus.state, 2);
    pulse_start();
    check("t5_start_ignored", bus.state, 2);
    pulse_stop();
    check("t5_wait_stop", bus.state, 0);
    check("t5_wait_stop_rst", bus.mmcm_reset, 1);

    // Async reset in FLUSH
    bus.mmcm_locked = 1'b1;
    tick(3);
    pulse_start();
    tick(4);
    check("t6_wait", bus.state, 2);
    tick(1);
    check("t6_flush", bus.state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_state", bus.state, 0);
    check("t6_async_mmcm", bus.mmcm_reset, 1);
    check("t6_async_dp", bus.dp_enable, 0);
    check("t6_async_err", bus.err, 0);
    check("t6_async_lost", bus.lock_lost_cnt, 0);
    check("t6_async_bypass", bus.bypass, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("t6_no_resume", bus.state, 0);
    check("t6_no_resume_dp", bus.dp_enable, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
